// File: rtl/prime_check_sequencer_if.sv
// prime_check_sequencer_if
//  Handshake bundle between the operand source, the prime-check sequencer and
//  the result consumer.
//
//  Signals
//   in_valid   source -> seq   operand offered
//   in_ready   seq -> source   sequencer can take an operand this cycle
//   data_in    source -> seq   operand, sampled only on accept
//   out_valid  seq -> consumer result valid, held until out_ready
//   out_ready  consumer -> seq consumer takes the result
//   is_prime   seq -> consumer 1 = operand is prime
//   div_mask   seq -> consumer divisibility flags for 2,3,5,7,11,13 (bit 0 = 2)
//   busy       seq -> anyone   sequencer is working on an operand
//
//  Modports
//   slave   the sequencer's view
//   master  the view of whatever drives operands and consumes results
interface prime_check_sequencer_if #(
    parameter int WIDTH = 8
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] data_in;
    logic             out_valid;
    logic             out_ready;
    logic             is_prime;
    logic [5:0]       div_mask;
    logic             busy;

    modport slave (
        input  in_valid,
        input  data_in,
        input  out_ready,
        output in_ready,
        output out_valid,
        output is_prime,
        output div_mask,
        output busy
    );

    modport master (
        output in_valid,
        output data_in,
        output out_ready,
        input  in_ready,
        input  out_valid,
        input  is_prime,
        input  div_mask,
        input  busy
    );
endinterface

// File: rtl/prime_check_sequencer.sv
// prime_check_sequencer
//  Takes an 8-bit operand over a valid/ready handshake and decides whether it
//  is prime. The operand is shifted MSB-first through six serial residue
//  trackers (mod 2,3,5,7,11,13). Once every bit has been consumed the residues
//  become a divisibility mask and a prime verdict. The result is held until the
//  consumer takes it.
//
//  Parameters
//   WIDTH       operand width. Only 8 is meaningful: the primes up to 13 cover
//               every factor an 8-bit composite must have.
//   BIT_CYCLES  clocks each operand bit is held before the trackers consume it.
//
//  Ports
//   clk    rising-edge clock
//   reset  synchronous, active-high. Drops any operand in flight.
//   bus    slave side of prime_check_sequencer_if (in/out handshakes, is_prime,
//          div_mask, busy)
//
//  Timing: accept on edge T0 -> out_valid high after edge T0 + WIDTH*BIT_CYCLES + 2.
module prime_check_sequencer #(
    parameter int WIDTH      = 8,
    parameter int BIT_CYCLES = 1
) (
    input logic                    clk,
    input logic                    reset,
    prime_check_sequencer_if.slave bus
);

    localparam int NUM_PRIMES = 6;
    localparam int IDX_W      = $clog2(WIDTH);
    localparam int SUB_W      = (BIT_CYCLES > 1) ? $clog2(BIT_CYCLES) : 1;

    typedef enum logic [2:0] {
        IDLE,
        CLEAR,
        SHIFT,
        EVAL,
        DONE
    } state_t;

    function automatic int primeAt(input int i);
        case (i)
            0:       return 2;
            1:       return 3;
            2:       return 5;
            3:       return 7;
            4:       return 11;
            default: return 13;
        endcase
    endfunction

    state_t                  state_q, state_d;
    logic [WIDTH-1:0]        op_q, op_d;
    logic [IDX_W-1:0]        bit_idx_q, bit_idx_d;
    logic [SUB_W-1:0]        sub_q, sub_d;
    logic                    out_valid_q, out_valid_d;
    logic                    is_prime_q, is_prime_d;
    logic [NUM_PRIMES-1:0]   div_mask_q, div_mask_d;

    logic                    in_ready;
    logic                    accept;
    logic                    cur_bit;
    logic                    bit_tick;
    logic                    clear_en;
    logic                    shift_en;
    logic [NUM_PRIMES-1:0]   res_zero;
    logic [NUM_PRIMES-1:0]   eq_mask;

    // in_ready is masked by reset so no operand is taken on a reset cycle.
    assign in_ready = (state_q == IDLE) & ~reset;
    assign accept   = bus.in_valid & in_ready;

    // bit_tick marks the last sub-cycle of a bit period. That is when the
    // trackers consume the bit and the bit index moves on.
    assign cur_bit  = op_q[bit_idx_q];
    assign bit_tick = (sub_q == SUB_W'(BIT_CYCLES - 1));
    assign clear_en = (state_q == CLEAR);
    assign shift_en = (state_q == SHIFT) & bit_tick;

    // One serial residue tracker per prime. Each tracker is only as wide as
    // its prime needs. The doubled-plus-bit value is at most 2p-1, so a
    // single conditional subtract brings it back into 0..p-1.
    for (genvar g = 0; g < NUM_PRIMES; g++) begin : g_res
        localparam int             P     = primeAt(g);
        localparam int             RW    = $clog2(P);
        localparam logic [RW:0]    P_EXT = P[RW:0];

        logic [RW-1:0] res_q, res_d;
        logic [RW:0]   doubled;

        always_comb begin
            doubled = {res_q, cur_bit};
            res_d   = res_q;
            if (clear_en) begin
                res_d = '0;
            end else if (shift_en) begin
                res_d = (doubled >= P_EXT) ? RW'(doubled - P_EXT) : RW'(doubled);
            end
        end

        always_ff @(posedge clk) begin
            if (reset) begin
                res_q <= '0;
            end else begin
                res_q <= res_d;
            end
        end

        assign res_zero[g] = (res_q == '0);
        assign eq_mask[g]  = (op_q == P[WIDTH-1:0]);
    end

    // State and result registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            op_q        <= '0;
            bit_idx_q   <= '0;
            sub_q       <= '0;
            out_valid_q <= 1'b0;
            is_prime_q  <= 1'b0;
            div_mask_q  <= '0;
        end else begin
            state_q     <= state_d;
            op_q        <= op_d;
            bit_idx_q   <= bit_idx_d;
            sub_q       <= sub_d;
            out_valid_q <= out_valid_d;
            is_prime_q  <= is_prime_d;
            div_mask_q  <= div_mask_d;
        end
    end

    // Next-state logic. The verdict treats a prime's own divisibility flag as
    // harmless when the operand equals that prime. Operands below 2 are never
    // prime, and an operand of 0 sets every divisibility flag.
    always_comb begin
        state_d     = state_q;
        op_d        = op_q;
        bit_idx_d   = bit_idx_q;
        sub_d       = sub_q;
        out_valid_d = out_valid_q;
        is_prime_d  = is_prime_q;
        div_mask_d  = div_mask_q;

        case (state_q)
            IDLE: begin
                if (accept) begin
                    op_d    = bus.data_in;
                    state_d = CLEAR;
                end
            end
            CLEAR: begin
                bit_idx_d = IDX_W'(WIDTH - 1);
                sub_d     = '0;
                state_d   = SHIFT;
            end
            SHIFT: begin
                if (bit_tick) begin
                    sub_d = '0;
                    if (bit_idx_q == '0) begin
                        state_d = EVAL;
                    end else begin
                        bit_idx_d = bit_idx_q - IDX_W'(1);
                    end
                end else begin
                    sub_d = sub_q + SUB_W'(1);
                end
            end
            EVAL: begin
                div_mask_d  = res_zero;
                is_prime_d  = (op_q >= WIDTH'(2)) & ~|(res_zero & ~eq_mask);
                out_valid_d = 1'b1;
                state_d     = DONE;
            end
            DONE: begin
                if (out_valid_q & bus.out_ready) begin
                    out_valid_d = 1'b0;
                    state_d     = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign bus.in_ready  = in_ready;
    assign bus.out_valid = out_valid_q;
    assign bus.is_prime  = is_prime_q;
    assign bus.div_mask  = div_mask_q;
    assign bus.busy      = (state_q == CLEAR) | (state_q == SHIFT) | (state_q == EVAL);

endmodule

// File: tb/tb_prime_check_sequencer.sv
// tb_prime_check_sequencer
//  Two sequencers share clock and reset: dut1 with BIT_CYCLES=1 and dut3 with
//  BIT_CYCLES=3. Stimulus pushes the expected verdict for each accepted operand
//  into a per-DUT queue. One monitor process owns every comparison. It pops the
//  queue when a result appears, and it also runs the point probes the stimulus
//  asks for.
`timescale 1ns/1ps
module tb_prime_check_sequencer;

    localparam int WIDTH = 8;

    typedef struct {
        logic [7:0] op;
        logic       prime;
        logic [5:0] mask;
        int         acceptCycle;
        int         latency;
    } expect_t;

    logic clk   = 1'b0;
    logic reset = 1'b1;

    prime_check_sequencer_if #(.WIDTH(WIDTH)) bus1 ();
    prime_check_sequencer_if #(.WIDTH(WIDTH)) bus3 ();

    prime_check_sequencer #(.WIDTH(WIDTH), .BIT_CYCLES(1)) dut1 (
        .clk   (clk),
        .reset (reset),
        .bus   (bus1)
    );

    prime_check_sequencer #(.WIDTH(WIDTH), .BIT_CYCLES(3)) dut3 (
        .clk   (clk),
        .reset (reset),
        .bus   (bus3)
    );

    expect_t q1[$];
    expect_t q3[$];
    expect_t cur[2];
    bit      have[2];
    bit      known[2];

    int cycle         = 0;
    int errors        = 0;
    int checks        = 0;
    int readyMode     = 0;
    int timeouts      = 0;
    int timeoutsSeen  = 0;
    int probeResetReq = 0, probeResetDone = 0;
    int probeIdleReq  = 0, probeIdleDone  = 0;
    int probeBlockReq = 0, probeBlockDone = 0;
    int probeBusyReq  = 0, probeBusyDone  = 0;
    int finalReq      = 0, finalDone      = 0;

    initial forever #5 clk = ~clk;

    initial forever begin
        @(posedge clk);
        cycle++;
    end

    // Reference model: primality by trial division, plus divisibility by each
    // tracked prime.
    function automatic logic refIsPrime(input int n);
        if (n < 2) return 1'b0;
        for (int d = 2; d * d <= n; d++) begin
            if (n % d == 0) return 1'b0;
        end
        return 1'b1;
    endfunction

    function automatic logic [5:0] refMask(input int n);
        int         primes[6];
        logic [5:0] m;
        primes = '{2, 3, 5, 7, 11, 13};
        for (int i = 0; i < 6; i++) m[i] = ((n % primes[i]) == 0);
        return m;
    endfunction

    task automatic checkOutput(input string name, input int actual, input int expected);
        checks++;
        if (actual != expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0d, expected %0d (cycle %0d)", name, actual, expected, cycle);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Offer one operand and hold it until accepted. When track is set, the
    // expected response is queued along with the accept edge.
    task automatic applyStimulus(input int port, input logic [7:0] op, input bit track);
        int      waitCount;
        bit      rdy;
        expect_t e;
        waitCount = 0;
        rdy       = 1'b0;
        if (port == 0) begin
            bus1.in_valid = 1'b1;
            bus1.data_in  = op;
        end else begin
            bus3.in_valid = 1'b1;
            bus3.data_in  = op;
        end
        while (!rdy && waitCount < 400) begin
            rdy = (port == 0) ? bus1.in_ready : bus3.in_ready;
            if (!rdy) begin
                tick();
                waitCount++;
            end
        end
        if (!rdy) begin
            timeouts++;
        end else if (track) begin
            e.op          = op;
            e.prime       = refIsPrime(int'(op));
            e.mask        = refMask(int'(op));
            e.acceptCycle = cycle + 1;
            e.latency     = WIDTH * ((port == 0) ? 1 : 3) + 2;
            if (port == 0) q1.push_back(e);
            else q3.push_back(e);
        end
        if (rdy) tick();
        if (port == 0) begin
            bus1.in_valid = 1'b0;
            bus1.data_in  = 8'($urandom);
        end else begin
            bus3.in_valid = 1'b0;
            bus3.data_in  = 8'($urandom);
        end
    endtask

    task automatic drain();
        int n;
        n = 0;
        while ((q1.size() != 0 || q3.size() != 0 || bus1.out_valid || bus3.out_valid) && n < 1000) begin
            tick();
            n++;
        end
        if (n >= 1000) timeouts++;
    endtask

    // Compare a result when it first appears, then keep it under watch while
    // it is held.
    task automatic scoreResult(input int port);
        logic       ov, ip, rdyPrev;
        logic [5:0] dm;
        int         qs;
        if (port == 0) begin
            ov = bus1.out_valid; ip = bus1.is_prime; dm = bus1.div_mask;
            rdyPrev = bus1.out_ready; qs = q1.size();
        end else begin
            ov = bus3.out_valid; ip = bus3.is_prime; dm = bus3.div_mask;
            rdyPrev = bus3.out_ready; qs = q3.size();
        end
        if (ov && !have[port]) begin
            have[port] = 1'b1;
            if (qs == 0) begin
                known[port] = 1'b0;
                checkOutput($sformatf("spurious_result_port%0d", port), int'(ov), 0);
            end else begin
                if (port == 0) cur[port] = q1.pop_front();
                else cur[port] = q3.pop_front();
                known[port] = 1'b1;
                checkOutput($sformatf("is_prime(op=%0d,port%0d)", cur[port].op, port),
                            int'(ip), int'(cur[port].prime));
                checkOutput($sformatf("div_mask(op=%0d,port%0d)", cur[port].op, port),
                            int'(dm), int'(cur[port].mask));
                checkOutput($sformatf("latency(op=%0d,port%0d)", cur[port].op, port),
                            cycle - cur[port].acceptCycle, cur[port].latency);
            end
        end else if (ov && known[port]) begin
            checkOutput("hold_is_prime", int'(ip), int'(cur[port].prime));
            checkOutput("hold_div_mask", int'(dm), int'(cur[port].mask));
        end else if (!ov && have[port]) begin
            checkOutput("valid_dropped_without_ready", int'(rdyPrev), 1);
            have[port]  = 1'b0;
            known[port] = 1'b0;
        end
    endtask

    // Monitor: the only process that compares. It runs on falling edges.
    initial begin
        bus1.out_ready = 1'b1;
        bus3.out_ready = 1'b1;
        forever begin
            @(negedge clk);
            if (reset) begin
                have[0] = 1'b0; have[1] = 1'b0;
                known[0] = 1'b0; known[1] = 1'b0;
            end else begin
                scoreResult(0);
                scoreResult(1);
            end
            if (probeResetReq != probeResetDone) begin
                probeResetDone = probeResetReq;
                checkOutput("reset_out_valid", int'(bus1.out_valid), 0);
                checkOutput("reset_in_ready", int'(bus1.in_ready), 0);
                checkOutput("reset_busy", int'(bus1.busy), 0);
                checkOutput("reset_is_prime", int'(bus1.is_prime), 0);
                checkOutput("reset_div_mask", int'(bus1.div_mask), 0);
            end
            if (probeIdleReq != probeIdleDone) begin
                probeIdleDone = probeIdleReq;
                checkOutput("idle_in_ready", int'(bus1.in_ready), 1);
                checkOutput("idle_out_valid", int'(bus1.out_valid), 0);
                checkOutput("idle_busy", int'(bus1.busy), 0);
                checkOutput("idle_in_ready_port1", int'(bus3.in_ready), 1);
            end
            if (probeBlockReq != probeBlockDone) begin
                probeBlockDone = probeBlockReq;
                checkOutput("in_ready_while_done", int'(bus1.in_ready), 0);
                checkOutput("busy_while_done", int'(bus1.busy), 0);
            end
            if (probeBusyReq != probeBusyDone) begin
                probeBusyDone = probeBusyReq;
                checkOutput("busy_after_accept", int'(bus1.busy), 1);
                checkOutput("in_ready_while_busy", int'(bus1.in_ready), 0);
            end
            if (timeouts != timeoutsSeen) begin
                checkOutput("bounded_wait_expired", timeouts - timeoutsSeen, 0);
                timeoutsSeen = timeouts;
            end
            if (finalReq != finalDone) begin
                finalDone = finalReq;
                checkOutput("scoreboard_left_port0", q1.size(), 0);
                checkOutput("scoreboard_left_port1", q3.size(), 0);
            end
            case (readyMode)
                0:       bus1.out_ready = 1'b1;
                1:       bus1.out_ready = 1'b0;
                default: bus1.out_ready = ($urandom_range(0, 2) != 0);
            endcase
            bus3.out_ready = 1'b1;
        end
    end

    // Stimulus.
    initial begin
        int perm[256];
        int j;
        int t;
        int n;

        bus1.in_valid = 1'b0;
        bus1.data_in  = '0;
        bus3.in_valid = 1'b0;
        bus3.data_in  = '0;

        $display("[TB] start");
        reset = 1'b1;
        repeat (3) tick();
        probeResetReq++;
        tick();
        reset = 1'b0;
        probeIdleReq++;
        tick();

        // Reset in the middle of shifting 143: the operand must vanish.
        applyStimulus(0, 8'd143, 1'b0);
        repeat (3) tick();
        reset = 1'b1;
        tick();
        tick();
        probeResetReq++;
        tick();
        reset = 1'b0;
        probeIdleReq++;
        tick();
        probeIdleReq++;
        repeat (15) tick();

        // 143 = 11*13, checked end to end.
        applyStimulus(0, 8'd143, 1'b1);
        probeBusyReq++;
        drain();

        // Primes at both ends of the range, then 0 and 1.
        applyStimulus(0, 8'd2, 1'b1);
        applyStimulus(0, 8'd13, 1'b1);
        applyStimulus(0, 8'd251, 1'b1);
        applyStimulus(0, 8'd0, 1'b1);
        applyStimulus(0, 8'd1, 1'b1);
        drain();

        // 255 held against backpressure. New operands are offered meanwhile.
        readyMode = 1;
        tick();
        applyStimulus(0, 8'd255, 1'b1);
        n = 0;
        while (!bus1.out_valid && n < 100) begin
            tick();
            n++;
        end
        if (n >= 100) timeouts++;
        for (int i = 0; i < 20; i++) begin
            if (i == 3 || i == 8 || i == 13) begin
                bus1.in_valid = 1'b1;
                bus1.data_in  = 8'd7;
                probeBlockReq++;
            end else begin
                bus1.in_valid = 1'b0;
            end
            tick();
        end
        bus1.in_valid = 1'b0;
        readyMode = 0;
        tick();
        probeIdleReq++;
        tick();
        drain();

        // Stretched bit period on the second instance.
        applyStimulus(1, 8'd221, 1'b1);
        applyStimulus(1, 8'd97, 1'b1);
        applyStimulus(1, 8'd0, 1'b1);
        drain();

        // Every operand, in shuffled order, with random gaps and backpressure.
        readyMode = 2;
        for (int i = 0; i < 256; i++) perm[i] = i;
        for (int i = 255; i > 0; i--) begin
            j = $urandom_range(0, i);
            t = perm[i];
            perm[i] = perm[j];
            perm[j] = t;
        end
        for (int i = 0; i < 256; i++) begin
            applyStimulus(0, 8'(perm[i]), 1'b1);
            repeat ($urandom_range(0, 2)) tick();
        end
        drain();
        readyMode = 0;

        finalReq++;
        tick();
        tick();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
